// File: rtl/audio_pkg.sv
// Shared types for the decimating frame buffer.
//   sample_t   : default-width signed sample
//   rd_state_t : read-side FSM states
//   IDX_W      : frame index width for the default frame length
package audio_pkg;

  localparam int unsigned WIDTH_DEF     = 8;
  localparam int unsigned FRAME_LEN_DEF = 64;
  localparam int unsigned IDX_W         = $clog2(FRAME_LEN_DEF);

  typedef logic signed [WIDTH_DEF-1:0] sample_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_STREAM
  } rd_state_t;

endpackage

// File: rtl/decim_frame_buffer_if.sv
// Frame stream towards the spectral-analysis stage.
//   m_data_out  : beat sample (signed)
//   m_valid_out : beat valid
//   m_ready_in  : sink accepts beat
//   m_last_out  : final beat of a frame
//   m_index_out : position of the beat within its frame
// master = frame buffer side, slave = consumer side.
interface decim_frame_buffer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 6
);

  logic signed [WIDTH-1:0] m_data_out;
  logic                    m_valid_out;
  logic                    m_ready_in;
  logic                    m_last_out;
  logic [IDX_W-1:0]        m_index_out;

  modport master (
    output m_data_out,
    output m_valid_out,
    output m_last_out,
    output m_index_out,
    input  m_ready_in
  );

  modport slave (
    input  m_data_out,
    input  m_valid_out,
    input  m_last_out,
    input  m_index_out,
    output m_ready_in
  );

endinterface

// File: rtl/frame_bank_ram.sv
// Simple dual-port sample store, both frame banks in one array.
//   clk   : clock
//   we    : write enable
//   waddr : write address {bank, index}
//   wdata : write data
//   raddr : read address {bank, index}, read every cycle
//   rdata : registered read data (1-cycle latency)
// No reset on the array or the read register so it maps onto block RAM.
module frame_bank_ram #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/decim_frame_buffer.sv
// Decimating ping-pong frame buffer between the FIR filter and the spectral stage.
// Keeps every DECIM-th sample, packs kept samples into FRAME_LEN-sample frames in
// two banks, and streams each completed frame over a valid/ready interface.
//   clk_in          : clock
//   rst_n_in        : asynchronous active-low reset
//   sample_in       : filtered sample (signed)
//   sample_valid_in : one-cycle pulse marking a new sample
//   m               : frame stream (master modport)
//   overflow_out    : sticky, a kept sample was dropped with both banks full
module decim_frame_buffer
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DECIM     = 4,
  parameter int unsigned FRAME_LEN = 64
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic                    sample_valid_in,
  decim_frame_buffer_if.master    m,
  output logic                    overflow_out
);

  localparam int unsigned IdxW = $clog2(FRAME_LEN);
  localparam int unsigned DecW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FRAME_LEN - 1);
  localparam logic [DecW-1:0] DecLast = DecW'(DECIM - 1);

  // Write side
  logic [DecW-1:0] dec_cnt_q, dec_cnt_d;
  logic [IdxW-1:0] wr_ptr_q, wr_ptr_d;
  logic            wr_bank_q, wr_bank_d, wr_bank_eff;
  logic [1:0]      full_q, full_d;
  logic            overflow_q, overflow_d;
  logic            keep, hold, rel, wr_en, drop;

  // Read side
  rd_state_t       state_q, state_d;
  logic            rd_bank_q, rd_bank_d;
  logic [IdxW-1:0] rd_idx_q, rd_idx_d;
  logic [WIDTH-1:0] rd_data;

  assign keep = sample_valid_in && (dec_cnt_q == '0);
  // Writer parks on its own full bank until the reader frees the other one.
  assign hold = full_q[wr_bank_q];
  assign rel  = (state_q == R_STREAM) && m.m_ready_in && (rd_idx_q == LastIdx);
  // A release in the same cycle wins: the writer moves straight into the freed bank.
  assign wr_bank_eff = (hold && rel) ? rd_bank_q : wr_bank_q;
  assign wr_en = keep && (!hold || rel);
  assign drop  = keep && hold && !rel;

  always_comb begin
    dec_cnt_d = dec_cnt_q;
    if (sample_valid_in) begin
      dec_cnt_d = (dec_cnt_q == DecLast) ? '0 : dec_cnt_q + 1'b1;
    end
  end

  always_comb begin
    full_d     = full_q;
    wr_bank_d  = wr_bank_eff;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q | drop;
    if (rel) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_ptr_q == LastIdx) begin
        full_d[wr_bank_eff] = 1'b1;
        // full_d already reflects a same-cycle release of the other bank.
        if (!full_d[~wr_bank_eff]) begin
          wr_bank_d = ~wr_bank_eff;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dec_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      wr_bank_q  <= 1'b0;
      full_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      dec_cnt_q  <= dec_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_bank_q  <= wr_bank_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow_out = overflow_q;

  // Read FSM: state register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= R_IDLE;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  // Read FSM: next state
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    case (state_q)
      R_IDLE: begin
        if (|full_q) begin
          // Oldest frame is the bank the writer is not on, when that one is full.
          rd_bank_d = full_q[~wr_bank_q] ? ~wr_bank_q : wr_bank_q;
          state_d   = R_FETCH;
        end
      end
      R_FETCH: begin
        rd_idx_d = '0;
        state_d  = R_STREAM;
      end
      R_STREAM: begin
        if (m.m_ready_in) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (rd_idx_q == LastIdx) begin
            if (full_q[~rd_bank_q]) begin
              rd_bank_d = ~rd_bank_q;
              state_d   = R_FETCH;
            end else begin
              state_d = R_IDLE;
            end
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // Read FSM: outputs. The RAM output register is the read-ahead stage: it is
  // re-addressed with the next index on a transfer and with the same index on a
  // stall, so the presented beat holds while the sink is not ready.
  always_comb begin
    m.m_valid_out = 1'b0;
    m.m_data_out  = '0;
    m.m_index_out = '0;
    m.m_last_out  = 1'b0;
    if (state_q == R_STREAM) begin
      m.m_valid_out = 1'b1;
      m.m_data_out  = rd_data;
      m.m_index_out = rd_idx_q;
      m.m_last_out  = (rd_idx_q == LastIdx);
    end
  end

  frame_bank_ram #(
    .WIDTH (WIDTH),
    .DEPTH (2 * FRAME_LEN)
  ) u_ram (
    .clk   (clk_in),
    .we    (wr_en),
    .waddr ({wr_bank_eff, wr_ptr_q}),
    .wdata (sample_in),
    .raddr ({rd_bank_q, rd_idx_d}),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_decim_frame_buffer.sv
// Bench for decim_frame_buffer (WIDTH 8, FRAME_LEN 8; one DECIM 4 and one DECIM 1 instance).
// The reference model works on whole frames: kept samples go into a partial frame,
// completed frames queue up (at most two outstanding), and each observed beat is
// checked against the head of the expected queue.
module tb_decim_frame_buffer;

  localparam int D0 = 4;
  localparam int FL = 8;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  logic [7:0] s0, s1;
  logic sv0, sv1;
  logic ovf0, ovf1;

  always #5 clk = ~clk;

  decim_frame_buffer_if #(.WIDTH(8), .IDX_W(3)) if0 ();
  decim_frame_buffer_if #(.WIDTH(8), .IDX_W(3)) if1 ();

  decim_frame_buffer #(.WIDTH(8), .DECIM(4), .FRAME_LEN(8)) dut0 (
    .clk_in          (clk),
    .rst_n_in        (rst0),
    .sample_in       (s0),
    .sample_valid_in (sv0),
    .m               (if0),
    .overflow_out    (ovf0)
  );

  decim_frame_buffer #(.WIDTH(8), .DECIM(1), .FRAME_LEN(8)) dut1 (
    .clk_in          (clk),
    .rst_n_in        (rst1),
    .sample_in       (s1),
    .sample_valid_in (sv1),
    .m               (if1),
    .overflow_out    (ovf1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model state
  int         m_seen;
  logic [7:0] m_cur[$];
  logic [7:0] m_exp[$];
  int         m_pending;
  int         m_consumed;
  bit         m_ovf;
  int         beats;

  function automatic void model_clear();
    m_seen = 0;
    m_cur.delete();
    m_exp.delete();
    m_pending = 0;
    m_consumed = 0;
    m_ovf = 1'b0;
  endfunction

  task automatic model_sample(input logic [7:0] v);
    if (m_seen % D0 == 0) begin
      if (m_pending == 2) begin
        m_ovf = 1'b1;
      end else begin
        m_cur.push_back(v);
        if (m_cur.size() == FL) begin
          foreach (m_cur[k]) m_exp.push_back(m_cur[k]);
          m_cur.delete();
          m_pending++;
        end
      end
    end
    m_seen++;
  endtask

  task automatic model_beat(input logic [7:0] d, input logic [2:0] idx, input logic last);
    logic [7:0] e;
    int pos;
    beats++;
    checks++;
    assert (m_exp.size() != 0) else begin
      errors++;
      $error("FAIL beat_unexpected: observed data=%0d idx=%0d, expected no beat", d, idx);
    end
    if (m_exp.size() != 0) begin
      e = m_exp.pop_front();
      pos = m_consumed % FL;
      chk("beat_data", d, e);
      chk("beat_idx", idx, pos);
      chk("beat_last", last, pos == FL - 1);
      m_consumed++;
      if (pos == FL - 1) m_pending--;
    end
  endtask

  // Per-cycle driver/sampler for dut0
  int cyc = 0;
  int first_valid_cyc = -1;
  logic o_valid, o_last, o_ovf;
  logic [7:0] o_data;
  logic [2:0] o_idx;
  bit stall_pend = 1'b0;
  logic [7:0] st_data;
  logic [2:0] st_idx;
  logic st_last;

  task automatic cycle0(input bit sv, input logic [7:0] val, input bit rdy);
    sv0 = sv;
    s0 = val;
    if0.m_ready_in = rdy;
    @(negedge clk);
    cyc++;
    o_valid = if0.m_valid_out;
    o_data  = if0.m_data_out;
    o_idx   = if0.m_index_out;
    o_last  = if0.m_last_out;
    o_ovf   = ovf0;
    chk("overflow", o_ovf, m_ovf);
    if (stall_pend) begin
      chk("stall_valid", o_valid, 1);
      chk("stall_data", o_data, st_data);
      chk("stall_idx", o_idx, st_idx);
      chk("stall_last", o_last, st_last);
    end
    if (!o_valid) chk("idle_last", o_last, 0);
    else if (first_valid_cyc < 0) first_valid_cyc = cyc;
    stall_pend = o_valid && !rdy;
    st_data = o_data;
    st_idx = o_idx;
    st_last = o_last;
    if (o_valid && rdy) model_beat(o_data, o_idx, o_last);
    if (sv) model_sample(val);
    @(posedge clk);
    #1;
  endtask

  task automatic reset0();
    rst0 = 1'b0;
    sv0 = 1'b0;
    s0 = '0;
    if0.m_ready_in = 1'b0;
    #1;
    chk("rst_valid", if0.m_valid_out, 0);
    chk("rst_data", if0.m_data_out, 0);
    chk("rst_idx", if0.m_index_out, 0);
    chk("rst_last", if0.m_last_out, 0);
    chk("rst_ovf", ovf0, 0);
    model_clear();
    stall_pend = 1'b0;
    first_valid_cyc = -1;
    @(posedge clk);
    #1;
    rst0 = 1'b1;
  endtask

  // dut1 driver, records every beat
  int c1 = 0;
  int b1_call[$];
  logic [7:0] b1_dat[$];
  logic [2:0] b1_idx[$];
  logic b1_last[$];

  task automatic cycle1(input bit sv, input logic [7:0] val);
    sv1 = sv;
    s1 = val;
    if1.m_ready_in = 1'b1;
    @(negedge clk);
    c1++;
    if (if1.m_valid_out) begin
      b1_call.push_back(c1);
      b1_dat.push_back(if1.m_data_out);
      b1_idx.push_back(if1.m_index_out);
      b1_last.push_back(if1.m_last_out);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat_base;
    int b0;
    int k;
    int p7;
    bit found;
    sv1 = 1'b0;
    s1 = '0;
    if1.m_ready_in = 1'b0;
    rst1 = 1'b0;
    model_clear();
    beats = 0;
    reset0();
    rst1 = 1'b1;

    // Ramp, ready high: one frame 0..28, valid two edges after the write of 28
    lat_base = 0;
    for (int i = 0; i < 32; i++) begin
      cycle0(1'b1, 8'(i), 1'b1);
      if (i == 28) lat_base = cyc;
      cycle0(1'b0, '0, 1'b1);
      cycle0(1'b0, '0, 1'b1);
    end
    for (int i = 0; i < 20; i++) cycle0(1'b0, '0, 1'b1);
    // first negedge with valid high is the third sampling point after the write edge
    chk("ramp_latency", first_valid_cyc - lat_base, 3);
    chk("ramp_drained", m_exp.size(), 0);
    chk("ramp_beats", beats, 8);

    // Backpressure: ready pattern 1,0,0 repeating
    reset0();
    k = 0;
    for (int i = 0; i < 32; i++) begin
      cycle0(1'b1, 8'(i), k % 3 == 0); k++;
      cycle0(1'b0, '0, k % 3 == 0); k++;
      cycle0(1'b0, '0, k % 3 == 0); k++;
    end
    for (int i = 0; i < 60; i++) begin
      cycle0(1'b0, '0, k % 3 == 0); k++;
    end
    chk("bp_drained", m_exp.size(), 0);

    // Overflow: ready low, 100 samples, then drain exactly two frames
    reset0();
    for (int i = 0; i < 100; i++) cycle0(1'b1, 8'(i), 1'b0);
    chk("ovf_flag", ovf0, 1);
    b0 = beats;
    for (int i = 0; i < 40; i++) cycle0(1'b0, '0, 1'b1);
    chk("ovf_beats", beats - b0, 16);
    for (int i = 100; i < 132; i++) cycle0(1'b1, 8'(i), 1'b1);
    for (int i = 0; i < 30; i++) cycle0(1'b0, '0, 1'b1);
    chk("ovf_after_drained", m_exp.size(), 0);
    chk("ovf_after_beats", beats - b0, 24);

    // Release of bank 0 coincides with the completing write of bank 1
    reset0();
    for (int i = 0; i < 60; i++) cycle0(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 7; i++) cycle0(1'b0, '0, 1'b1);
    cycle0(1'b1, 8'd60, 1'b1);
    chk("coin_last_idx", o_idx, 7);
    cycle0(1'b0, '0, 1'b1);
    chk("coin_gap1", o_valid, 0);
    cycle0(1'b0, '0, 1'b1);
    chk("coin_gap2", o_valid, 0);
    cycle0(1'b0, '0, 1'b1);
    chk("coin_stream", o_valid, 1);
    for (int i = 61; i < 96; i++) cycle0(1'b1, 8'(i), 1'b1);
    for (int i = 0; i < 30; i++) cycle0(1'b0, '0, 1'b1);
    chk("coin_ovf", ovf0, 0);
    chk("coin_drained", m_exp.size(), 0);

    // Reset while beat 3 is presented
    reset0();
    found = 1'b0;
    for (int i = 0; i < 32; i++) cycle0(1'b1, 8'(i), 1'b1);
    for (int i = 0; i < 60 && !found; i++) begin
      cycle0(1'b0, '0, 1'b1);
      if (o_valid && o_idx == 3'd2) found = 1'b1;
    end
    chk("mid_found_beat", found, 1);
    reset0();
    for (int i = 200; i < 232; i++) cycle0(1'b1, 8'(i), 1'b1);
    for (int i = 0; i < 30; i++) cycle0(1'b0, '0, 1'b1);
    chk("mid_drained", m_exp.size(), 0);

    // DECIM = 1 instance: two frames back to back with one fetch gap
    rst1 = 1'b0;
    #1;
    chk("dec1_rst_valid", if1.m_valid_out, 0);
    @(posedge clk);
    #1;
    rst1 = 1'b1;
    p7 = 0;
    for (int i = 0; i < 16; i++) begin
      cycle1(1'b1, 8'(i));
      if (i == 7) p7 = c1;
    end
    for (int i = 0; i < 30; i++) cycle1(1'b0, '0);
    chk("dec1_beats", b1_call.size(), 16);
    for (int i = 0; i < 16 && i < b1_call.size(); i++) begin
      chk("dec1_data", b1_dat[i], i);
      chk("dec1_idx", b1_idx[i], i % FL);
      chk("dec1_last", b1_last[i], i % FL == FL - 1);
      chk("dec1_timing", b1_call[i], p7 + 3 + i + ((i >= FL) ? 1 : 0));
    end

    // Random traffic: moderate then heavy backpressure
    reset0();
    for (int i = 0; i < 600; i++) begin
      cycle0(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 9) < 6);
    end
    for (int i = 0; i < 600; i++) begin
      cycle0(1'($urandom_range(0, 3) != 0), 8'($urandom), $urandom_range(0, 9) == 0);
    end
    for (int i = 0; i < 60; i++) cycle0(1'b0, '0, 1'b1);
    chk("rand_drained", m_exp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
